// File: rtl/seq_scaler.sv
// ---------------------------------------------------------------------------
// seq_scaler
//   Multi-cycle unsigned scaler: y = sat(round_or_trunc(x * COEF / 2^FRAC)).
//   One shift-add step per clock over the bits of the latched operand, then
//   a final cycle applies rounding, the fractional shift and saturation.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_start     request a new operation (ignored while busy)
//   i_x         unsigned operand, sampled with i_start
//   i_rnd_mode  0 = truncate, 1 = round-half-up, sampled with i_start
//   o_busy      operation in progress (state is not idle)
//   o_done      one-cycle pulse when o_y / o_ovf are updated
//   o_y         scaled result, held until the next done
//   o_ovf       result saturated, held with o_y
// ---------------------------------------------------------------------------
module seq_scaler #(
    parameter int unsigned IN_W   = 6,
    parameter int unsigned COEF   = 57,
    parameter int unsigned COEF_W = 7,
    parameter int unsigned FRAC   = 1,
    parameter int unsigned OUT_W  = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [IN_W-1:0]  i_x,
    input  logic             i_rnd_mode,
    output logic             o_busy,
    output logic             o_done,
    output logic [OUT_W-1:0] o_y,
    output logic             o_ovf
);

    localparam int unsigned ACC_W  = IN_W + COEF_W + 1;
    localparam int unsigned CNT_W  = $clog2(IN_W + 1);
    localparam int unsigned SUM_W  = ACC_W + 1;
    // Wide enough for the rounded sum and for the output slice.
    localparam int unsigned WIDE_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    // 2^(FRAC-1) when FRAC > 0, zero when FRAC == 0.
    localparam logic [WIDE_W-1:0] RND_ADD = (WIDE_W'(1) << FRAC) >> 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [IN_W-1:0]   r_x;
    logic              r_rnd;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [OUT_W-1:0]  r_y;
    logic              r_ovf;
    logic              r_done;

    logic              w_accept;
    logic              w_calc;
    logic              w_fin;
    logic              w_last;
    logic [IN_W-1:0]   w_xsh;
    logic              w_xbit;
    logic [ACC_W-1:0]  w_addend;
    logic [WIDE_W-1:0] w_wide;
    logic              w_sat;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StCalc;
            StCalc:  if (w_last)  w_state_next = StFin;
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy   = (r_state != StIdle);
        w_accept = (r_state == StIdle) && i_start;
        w_calc   = (r_state == StCalc);
        w_fin    = (r_state == StFin);
    end

    // Datapath helpers
    always_comb begin
        w_last   = (r_cnt == CNT_W'(IN_W - 1));
        w_xsh    = r_x >> r_cnt;
        w_xbit   = |(w_xsh & IN_W'(1));
        w_addend = w_xbit ? (ACC_W'(COEF) << r_cnt) : '0;
        // Full-width sum before the shift so the saturation check sees every bit.
        w_wide   = (WIDE_W'(r_acc) + (r_rnd ? RND_ADD : '0)) >> FRAC;
        w_sat    = |(w_wide >> OUT_W);
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x    <= '0;
            r_rnd  <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_x   <= i_x;
                r_rnd <= i_rnd_mode;
                r_acc <= '0;
                r_cnt <= '0;
            end
            if (w_calc) begin
                r_acc <= r_acc + w_addend;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fin) begin
                r_y    <= w_sat ? '1 : w_wide[OUT_W-1:0];
                r_ovf  <= w_sat;
                r_done <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_y    = r_y;
    assign o_ovf  = r_ovf;

endmodule
